// File: rtl/register_writeback.sv
// TD4 write-back stage: decodes the opcode into register load enables, updates A/B/OUT/PC
// and the carry flag on each retired instruction, and counts retirements.
module register_writeback #(
  parameter int PC_W  = 4,
  parameter int RET_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [3:0]       alu_y,
  input  logic             alu_c,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic [3:0]       out,
  output logic [PC_W-1:0]  pc,
  output logic             c_flag,
  output logic [RET_W-1:0] retired,
  output logic             wb_valid
);

  logic load_a;
  logic load_b;
  logic load_out;
  logic load_pc;

  // JNC tests the flag registered by the previous instruction, not this cycle's alu_c.
  always_comb begin
    load_a   = ~op[3] & ~op[2];
    load_b   = ~op[3] &  op[2];
    load_out =  op[3] & ~op[2];
    load_pc  =  op[3] &  op[2] & (op[0] | ~c_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      out      <= '0;
      pc       <= '0;
      c_flag   <= 1'b0;
      retired  <= '0;
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= en;
      if (en) begin
        if (load_a)   a   <= alu_y;
        if (load_b)   b   <= alu_y;
        if (load_out) out <= alu_y;
        pc      <= load_pc ? PC_W'(alu_y) : pc + PC_W'(1);
        c_flag  <= alu_c;
        retired <= retired + RET_W'(1);
      end
    end
  end

endmodule
